// File: rtl/rob_completion_unit.sv
// rtl/rob_completion_unit.sv - execution-unit completion buffering, ROB write-back arbitration, oldest-redirect tracking
module rob_completion_unit #(
    parameter int NUM_UNITS  = 4,
    parameter int WB_PORTS   = 2,
    parameter int PTR_BITS   = 6,
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_BITS  = 64
) (
    input  logic                           clk_in,
    input  logic                           rst_N_in,
    input  logic                           flush_in,
    input  logic [PTR_BITS-1:0]            rob_head_in,
    input  logic [NUM_UNITS-1:0]           unit_valid_in,
    output logic [NUM_UNITS-1:0]           unit_ready_out,
    input  logic [NUM_UNITS*PTR_BITS-1:0]  unit_ptr_in,
    input  logic [NUM_UNITS*2-1:0]         unit_code_in,
    input  logic [NUM_UNITS*ADDR_BITS-1:0] unit_target_in,
    output logic [WB_PORTS-1:0]            wb_valid_out,
    output logic [WB_PORTS*PTR_BITS-1:0]   wb_ptr_out,
    output logic [WB_PORTS*2-1:0]          wb_code_out,
    output logic                           redirect_valid_out,
    output logic [ADDR_BITS-1:0]           redirect_pc_out,
    output logic [PTR_BITS-1:0]            redirect_ptr_out
);
    localparam int IDX_BITS  = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS  = $clog2(FIFO_DEPTH + 1);
    localparam int UNIT_BITS = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    // Per-unit circular buffers; storage carries no reset, only indices/counts do
    logic [PTR_BITS-1:0]  r_mem_ptr  [NUM_UNITS][FIFO_DEPTH];
    logic [1:0]           r_mem_code [NUM_UNITS][FIFO_DEPTH];
    logic [ADDR_BITS-1:0] r_mem_tgt  [NUM_UNITS][FIFO_DEPTH];
    logic [IDX_BITS-1:0]  r_rd       [NUM_UNITS];
    logic [IDX_BITS-1:0]  r_wr       [NUM_UNITS];
    logic [CNT_BITS-1:0]  r_cnt      [NUM_UNITS];
    logic [UNIT_BITS-1:0] r_rr;

    logic [WB_PORTS-1:0]          r_wb_valid;
    logic [WB_PORTS*PTR_BITS-1:0] r_wb_ptr;
    logic [WB_PORTS*2-1:0]        r_wb_code;
    logic                         r_redir_valid;
    logic [ADDR_BITS-1:0]         r_redir_pc;
    logic [PTR_BITS-1:0]          r_redir_ptr;

    logic [NUM_UNITS-1:0] w_push;
    logic [NUM_UNITS-1:0] w_pop;
    logic [PTR_BITS-1:0]  w_head_ptr  [NUM_UNITS];
    logic [1:0]           w_head_code [NUM_UNITS];
    logic [ADDR_BITS-1:0] w_head_tgt  [NUM_UNITS];
    logic [PTR_BITS-1:0]  w_head_age  [NUM_UNITS];
    logic [WB_PORTS-1:0]  w_gnt_vld;
    logic [UNIT_BITS-1:0] w_gnt_unit  [WB_PORTS];
    logic                 w_cand_vld;
    logic [PTR_BITS-1:0]  w_cand_ptr;
    logic [ADDR_BITS-1:0] w_cand_pc;
    logic [PTR_BITS-1:0]  w_cand_age;
    logic [PTR_BITS-1:0]  w_pend_age;
    logic                 w_redir_load;

    // Ready comes from the registered count, so a full buffer cannot refill on its drain cycle
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_ready_out[u] = (r_cnt[u] < CNT_BITS'(FIFO_DEPTH)) && !flush_in;
            w_push[u]         = unit_valid_in[u] && unit_ready_out[u];
            w_head_ptr[u]     = r_mem_ptr[u][r_rd[u]];
            w_head_code[u]    = r_mem_code[u][r_rd[u]];
            w_head_tgt[u]     = r_mem_tgt[u][r_rd[u]];
            w_head_age[u]     = w_head_ptr[u] - rob_head_in;
        end
    end

    // Round-robin scan from r_rr: first WB_PORTS non-empty buffers win, in scan order
    always_comb begin
        int n;
        int u;
        n         = 0;
        w_pop     = '0;
        w_gnt_vld = '0;
        for (int k = 0; k < WB_PORTS; k++) w_gnt_unit[k] = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            u = (int'(r_rr) + i) % NUM_UNITS;
            if (r_cnt[u] != '0 && n < WB_PORTS) begin
                w_pop[u]      = 1'b1;
                w_gnt_vld[n]  = 1'b1;
                w_gnt_unit[n] = UNIT_BITS'(u);
                n             = n + 1;
            end
        end
    end

    // Oldest granted mispredict/trap, then compare against the pending redirect with today's head
    always_comb begin
        w_cand_vld = 1'b0;
        w_cand_ptr = '0;
        w_cand_pc  = '0;
        w_cand_age = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (w_gnt_vld[k] && w_head_code[w_gnt_unit[k]][1]) begin
                if (!w_cand_vld || w_head_age[w_gnt_unit[k]] < w_cand_age) begin
                    w_cand_vld = 1'b1;
                    w_cand_ptr = w_head_ptr[w_gnt_unit[k]];
                    w_cand_pc  = w_head_tgt[w_gnt_unit[k]];
                    w_cand_age = w_head_age[w_gnt_unit[k]];
                end
            end
        end
        w_pend_age   = r_redir_ptr - rob_head_in;
        w_redir_load = w_cand_vld && (!r_redir_valid || w_cand_age < w_pend_age);
    end

    // Payload storage written on accept
    always_ff @(posedge clk_in) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (w_push[u]) begin
                r_mem_ptr[u][r_wr[u]]  <= unit_ptr_in[u*PTR_BITS +: PTR_BITS];
                r_mem_code[u][r_wr[u]] <= unit_code_in[u*2 +: 2];
                r_mem_tgt[u][r_wr[u]]  <= unit_target_in[u*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    // Control state: buffer indices, round-robin pointer, write-back and redirect registers
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                r_rd[u]  <= '0;
                r_wr[u]  <= '0;
                r_cnt[u] <= '0;
            end
            r_rr          <= '0;
            r_wb_valid    <= '0;
            r_wb_ptr      <= '0;
            r_wb_code     <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
            r_redir_ptr   <= '0;
        end else if (flush_in) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                r_rd[u]  <= '0;
                r_wr[u]  <= '0;
                r_cnt[u] <= '0;
            end
            r_wb_valid    <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
            r_redir_ptr   <= '0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (w_push[u]) r_wr[u] <= r_wr[u] + IDX_BITS'(1);
                if (w_pop[u])  r_rd[u] <= r_rd[u] + IDX_BITS'(1);
                r_cnt[u] <= r_cnt[u] + CNT_BITS'(w_push[u]) - CNT_BITS'(w_pop[u]);
            end
            for (int k = 0; k < WB_PORTS; k++) begin
                r_wb_valid[k]                  <= w_gnt_vld[k];
                r_wb_ptr[k*PTR_BITS +: PTR_BITS] <= w_gnt_vld[k] ? w_head_ptr[w_gnt_unit[k]] : '0;
                r_wb_code[k*2 +: 2]            <= w_gnt_vld[k] ? w_head_code[w_gnt_unit[k]] : 2'b00;
            end
            if (|w_gnt_vld) begin
                r_rr <= (int'(r_rr) == NUM_UNITS - 1) ? '0 : r_rr + 1'b1;
            end
            if (w_redir_load) begin
                r_redir_valid <= 1'b1;
                r_redir_pc    <= w_cand_pc;
                r_redir_ptr   <= w_cand_ptr;
            end
        end
    end

    assign wb_valid_out       = r_wb_valid;
    assign wb_ptr_out         = r_wb_ptr;
    assign wb_code_out        = r_wb_code;
    assign redirect_valid_out = r_redir_valid;
    assign redirect_pc_out    = r_redir_pc;
    assign redirect_ptr_out   = r_redir_ptr;

endmodule

// File: tb/tb_rob_completion_unit.sv
// tb/tb_rob_completion_unit.sv - randomized bench for rob_completion_unit against a queue-based reference model
module tb_rob_completion_unit;
    localparam int NU = 4;
    localparam int NP = 2;
    localparam int PB = 6;
    localparam int AB = 64;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [PB-1:0] ptr;
        logic [1:0]    code;
        logic [AB-1:0] tgt;
    } pkt_t;

    logic                clk_in = 1'b0;
    logic                rst_N_in = 1'b0;
    logic                flush_in = 1'b0;
    logic [PB-1:0]       rob_head_in = '0;
    logic [NU-1:0]       unit_valid_in = '0;
    logic [NU-1:0]       unit_ready_out;
    logic [NU*PB-1:0]    unit_ptr_in = '0;
    logic [NU*2-1:0]     unit_code_in = '0;
    logic [NU*AB-1:0]    unit_target_in = '0;
    logic [NP-1:0]       wb_valid_out;
    logic [NP*PB-1:0]    wb_ptr_out;
    logic [NP*2-1:0]     wb_code_out;
    logic                redirect_valid_out;
    logic [AB-1:0]       redirect_pc_out;
    logic [PB-1:0]       redirect_ptr_out;

    rob_completion_unit dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in), .flush_in(flush_in), .rob_head_in(rob_head_in),
        .unit_valid_in(unit_valid_in), .unit_ready_out(unit_ready_out), .unit_ptr_in(unit_ptr_in),
        .unit_code_in(unit_code_in), .unit_target_in(unit_target_in), .wb_valid_out(wb_valid_out),
        .wb_ptr_out(wb_ptr_out), .wb_code_out(wb_code_out), .redirect_valid_out(redirect_valid_out),
        .redirect_pc_out(redirect_pc_out), .redirect_ptr_out(redirect_ptr_out)
    );

    always #5 clk_in = ~clk_in;

    int   n_vec = 0;
    int   n_err = 0;

    // Reference state: per-unit queues of accepted packets, arbitration start, expected outputs
    pkt_t          q [NU][$];
    int            rr = 0;
    logic [NP-1:0] e_wbv = '0;
    logic [PB-1:0] e_wbp [NP];
    logic [1:0]    e_wbc [NP];
    logic          e_rv = 1'b0;
    logic [PB-1:0] e_rptr = '0;
    logic [AB-1:0] e_rpc = '0;

    // Stimulus: each unit's offered packet, held until accepted
    logic [NU-1:0] pv = '0;
    pkt_t          pk [NU];
    logic [PB-1:0] head = '0;
    logic          fl = 1'b0;
    int            gen_mode = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int age(input logic [PB-1:0] p, input logic [PB-1:0] h);
        logic [PB-1:0] d;
        d = p - h;
        return int'(d);
    endfunction

    function automatic pkt_t rand_pkt();
        pkt_t p;
        int   r;
        p.ptr  = PB'($urandom_range(0, 63));
        r      = $urandom_range(0, 9);
        p.code = (r < 6) ? 2'd0 : (r == 6) ? 2'd1 : (r == 7 || r == 8) ? 2'd2 : 2'd3;
        p.tgt  = {$urandom, $urandom};
        return p;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < NU; u++) q[u].delete();
        rr    = 0;
        e_wbv = '0;
        e_rv  = 1'b0;
    endtask

    // One clock: drive, compare against the model, advance the model, step past the edge
    task automatic cycle();
        logic [NU-1:0] e_rdy;
        int            n;
        int            u;
        logic          cf;
        pkt_t          c;
        pkt_t          g;
        for (int i = 0; i < NU; i++) begin
            unit_valid_in[i]          = pv[i];
            unit_ptr_in[i*PB +: PB]   = pk[i].ptr;
            unit_code_in[i*2 +: 2]    = pk[i].code;
            unit_target_in[i*AB +: AB] = pk[i].tgt;
        end
        rob_head_in = head;
        flush_in    = fl;
        #1;
        for (int i = 0; i < NU; i++) e_rdy[i] = (q[i].size() < DEPTH) && !fl;
        check("ready", 64'(unit_ready_out), 64'(e_rdy));
        check("wb_valid", 64'(wb_valid_out), 64'(e_wbv));
        for (int k = 0; k < NP; k++) begin
            if (e_wbv[k]) begin
                check("wb_ptr", 64'(wb_ptr_out[k*PB +: PB]), 64'(e_wbp[k]));
                check("wb_code", 64'(wb_code_out[k*2 +: 2]), 64'(e_wbc[k]));
            end
        end
        check("redir_valid", 64'(redirect_valid_out), 64'(e_rv));
        if (e_rv) begin
            check("redir_ptr", 64'(redirect_ptr_out), 64'(e_rptr));
            check("redir_pc", redirect_pc_out, e_rpc);
        end
        if (fl) begin
            for (int i = 0; i < NU; i++) q[i].delete();
            e_wbv = '0;
            e_rv  = 1'b0;
        end else begin
            n     = 0;
            cf    = 1'b0;
            c     = '0;
            e_wbv = '0;
            for (int i = 0; i < NU; i++) begin
                u = (rr + i) % NU;
                if (q[u].size() > 0 && n < NP) begin
                    g = q[u].pop_front();
                    e_wbv[n] = 1'b1;
                    e_wbp[n] = g.ptr;
                    e_wbc[n] = g.code;
                    if (g.code >= 2'd2 && (!cf || age(g.ptr, head) < age(c.ptr, head))) begin
                        cf = 1'b1;
                        c  = g;
                    end
                    n++;
                end
            end
            if (n > 0) rr = (rr + 1) % NU;
            if (cf && (!e_rv || age(c.ptr, head) < age(e_rptr, head))) begin
                e_rv   = 1'b1;
                e_rptr = c.ptr;
                e_rpc  = c.tgt;
            end
            for (int i = 0; i < NU; i++) begin
                if (pv[i] && e_rdy[i]) begin
                    q[i].push_back(pk[i]);
                    pv[i] = 1'b0;
                end
            end
        end
        @(posedge clk_in);
        @(negedge clk_in);
        for (int i = 0; i < NU; i++) begin
            if (!pv[i] && (gen_mode == 1 || (gen_mode == 2 && $urandom_range(0, 1) == 1))) begin
                pv[i] = 1'b1;
                pk[i] = rand_pkt();
            end
        end
        if (gen_mode == 2) begin
            head = PB'($urandom_range(0, 63));
            fl   = ($urandom_range(0, 24) == 0);
        end
    endtask

    task automatic offer(input int u, input logic [PB-1:0] p, input logic [1:0] cd, input logic [AB-1:0] t);
        pv[u]     = 1'b1;
        pk[u].ptr = p;
        pk[u].code = cd;
        pk[u].tgt = t;
    endtask

    initial begin
        for (int i = 0; i < NU; i++) pk[i] = '0;
        for (int k = 0; k < NP; k++) begin
            e_wbp[k] = '0;
            e_wbc[k] = '0;
        end
        #12;
        check("rst_wb_valid", 64'(wb_valid_out), 64'd0);
        check("rst_wb_ptr", 64'(wb_ptr_out), 64'd0);
        check("rst_wb_code", 64'(wb_code_out), 64'd0);
        check("rst_redir_valid", 64'(redirect_valid_out), 64'd0);
        check("rst_redir_pc", redirect_pc_out, 64'd0);
        check("rst_redir_ptr", 64'(redirect_ptr_out), 64'd0);
        @(negedge clk_in);
        rst_N_in = 1'b1;
        #1;
        check("rst_ready", 64'(unit_ready_out), 64'hF);

        // Single packet: two-edge latency, one-cycle pulse
        offer(0, 6'd5, 2'd0, 64'd0);
        cycle();
        check("single_early", 64'(wb_valid_out), 64'd0);
        cycle();
        check("single_valid", 64'(wb_valid_out), 64'd1);
        check("single_ptr", 64'(wb_ptr_out[PB-1:0]), 64'd5);
        check("single_code", 64'(wb_code_out[1:0]), 64'd0);
        cycle();
        check("single_pulse", 64'(wb_valid_out), 64'd0);

        // Oldest redirect across pointer wrap, then replace/no-replace
        head = 6'd60;
        offer(3, 6'd2, 2'd2, 64'h1000);
        offer(2, 6'd62, 2'd3, 64'h2000);
        cycle();
        cycle();
        check("redir_wrap_ptr", 64'(redirect_ptr_out), 64'd62);
        check("redir_wrap_pc", redirect_pc_out, 64'h2000);
        offer(0, 6'd61, 2'd2, 64'h3000);
        cycle();
        cycle();
        check("redir_older_ptr", 64'(redirect_ptr_out), 64'd61);
        offer(1, 6'd3, 2'd2, 64'h4000);
        cycle();
        cycle();
        check("redir_younger_ptr", 64'(redirect_ptr_out), 64'd61);
        check("redir_younger_pc", redirect_pc_out, 64'h3000);

        // Flush with packets buffered and a redirect pending
        for (int i = 0; i < NU; i++) offer(i, PB'(10 + i), 2'd0, 64'd0);
        cycle();
        fl = 1'b1;
        cycle();
        fl = 1'b0;
        check("flush_wb_valid", 64'(wb_valid_out), 64'd0);
        check("flush_redir", 64'(redirect_valid_out), 64'd0);
        for (int i = 0; i < 4; i++) cycle();

        // Saturating contention: every unit offers every cycle
        gen_mode = 1;
        for (int i = 0; i < NU; i++) if (!pv[i]) offer(i, PB'($urandom_range(0, 63)), 2'd0, 64'd0);
        for (int i = 0; i < 20; i++) cycle();

        // Random traffic with random head, codes and flushes
        gen_mode = 2;
        for (int i = 0; i < 400; i++) cycle();

        // Asynchronous reset between edges
        #2;
        rst_N_in = 1'b0;
        #1;
        check("arst_wb_valid", 64'(wb_valid_out), 64'd0);
        check("arst_wb_ptr", 64'(wb_ptr_out), 64'd0);
        check("arst_redir_valid", 64'(redirect_valid_out), 64'd0);
        check("arst_redir_pc", redirect_pc_out, 64'd0);
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        rst_N_in = 1'b1;
        gen_mode = 0;
        fl = 1'b0;
        pv = '0;
        offer(2, 6'd33, 2'd1, 64'd0);
        cycle();
        cycle();
        check("arst_after_valid", 64'(wb_valid_out), 64'd1);
        check("arst_after_ptr", 64'(wb_ptr_out[PB-1:0]), 64'd33);
        gen_mode = 2;
        for (int i = 0; i < 300; i++) cycle();
        gen_mode = 0;
        pv = '0;
        fl = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout n_err=%0d", n_err);
        $fatal(1, "timeout");
    end
endmodule
